b02_line_scheduler: RTL and testbench
=====================================

Name: b02_line_scheduler

Overview:
- Time-shares one b02-style serial recognizer (states A..G, pulse U) among NUM_LINES independent serial lines.
- Holds a saved recognizer context per line. Each cycle a round-robin arbiter grants at most one requesting line, and that line's context advances by one bit.
- Match pulses are tagged with the line index.
- Sits between the serial-line front ends and the event/status logic that consumes U.

Parameters:
- NUM_LINES, 4, number of serial lines; legal range 2..16.
- IDW, $clog2(NUM_LINES), width of the line index (derived; do not override).

Ports:
- clock  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req  input  NUM_LINES  per-line step request (level)
- linea  input  NUM_LINES  per-line serial bit, sampled on the edge that grants that line
- flush  input  NUM_LINES  per-line context clear to A (synchronous)
- gnt  output  NUM_LINES  registered one-hot; bit i high for one cycle after line i was stepped
- match_valid  output  1  registered; high for one cycle after a step that left state E
- match_line  output  IDW  registered; index of the line that produced the match
- stat_sel  input  IDW  statistics read select (STATS_EN)
- stat_cnt  output  8  statistics read data (STATS_EN)

Behaviour:
- Reset (asynchronous, active-high):
  - all ctx[i]=A; ptr=0
  - gnt=0, match_valid=0, match_line=0, stat counters=0
- Context encoding: 3 bits, A=0 .. G=6. Code 7 is illegal and is treated as A: next state B, u=0.
- Step function, combinational (s, bit -> s', u):
  - A->B
  - B: bit 0->C, bit 1->F
  - C: bit 0->D, bit 1->G
  - D->E
  - E->B
  - F->G
  - G: bit 0->E, bit 1->A
  - u=1 iff s==E
- Arbitration each cycle:
  - Eligible set = req & ~flush.
  - Winner = first eligible index searching ptr, ptr+1, ..., wrapping modulo NUM_LINES.
  - If no line is eligible: no step; gnt=0 and match_valid=0 next cycle; ptr unchanged.
- On the edge with winner w:
  - ctx[w] <= step(ctx[w], linea[w]).u and s' applied as defined above.
  - gnt <= onehot(w)
  - match_valid <= u
  - match_line <= w when u=1, else holds its previous value
  - ptr <= (w+1) mod NUM_LINES
- Latency: bit consumed on the granting edge; gnt and match visible in the following cycle.
- req is level-sensitive. Every grant consumes one bit. A requester must present a new bit while req is high and gnt is low or pulsing.
- A lone requester with req held high is granted every cycle.
- Flush:
  - flush[i]=1 sets ctx[i]=A at the edge.
  - Flush overrides a step: a flushed line is never granted in that cycle.
  - Flushing a non-winning line does not disturb the winner.
- Invariants:
  - gnt is one-hot or zero.
  - match_valid implies gnt[match_line]=1 in the same cycle.
  - Per line, two stepped grants that both produce u=1 are separated by at least 3 intervening grants of that line.

Optional Feature:
- Macro: B02_LINE_SCHEDULER_STATS_EN.
- With the macro:
  - per-line 8-bit match counter, saturating at 255
  - increments on that line's match; cleared by reset and by that line's flush
  - flush wins over a simultaneous increment
  - stat_cnt = counter[stat_sel], combinational read; out-of-range stat_sel reads 0
- Without the macro:
  - no counters; stat_cnt tied to 0
  - stat_sel ignored; ports retained so the interface is stable

Decomposition:
- Package b02_pkg:
  - typedef enum logic [2:0] b02_state_t {A..G}
  - localparam B02_RESET_STATE = A
  - localparam STAT_W = 8
- Sub-module b02_step: pure combinational step function (s, bit -> s', u), reusable by other b02-derived blocks.
- Arbiter stays inline: rotate-priority search.

Test Plan:
- Reset, then req[0]=1 held, linea[0]=0 held, other req=0:
  - gnt[0]=1 every cycle
  - first match_valid=1, match_line=0 after the 5th grant (A,B,C,D,E -> B)
  - subsequent matches every 4th grant
- req=4'b0101 held:
  - gnt alternates 0001, 0100, 0001, ...
  - req=4'b1111 gives gnt 0001, 0010, 0100, 1000, 0001
- Line 1 alone, linea sequence 1,1,1 from state B (B->F->G->A): no match_valid. The next bit steps A->B.
- Line 0 reaches E. In the cycle it would be granted, assert flush[0] with req[0]=1:
  - no grant, no match; ctx[0]=A
  - the next grant steps A->B
- Assert reset asynchronously mid-run, between edges, with two lines active:
  - gnt, match_valid, and ptr clear immediately
  - after release, the first grant goes to line 0
- With B02_LINE_SCHEDULER_STATS_EN, drive 260 matches on line 2:
  - stat_sel=2 reads 255
  - flush[2] returns 0
  - stat_sel=3 reads 0

Source files
------------

// File: rtl/b02_pkg.sv
// ---------------------------------------------------------------------------
// b02_pkg
//   Shared types and constants for b02-derived blocks.
//   - b02_state_t     : 3-bit recognizer state, A=0 .. G=6 (code 7 unused)
//   - B02_RESET_STATE : state a context returns to on reset or flush
//   - STAT_W          : width of the optional per-line match counters
//   - STAT_MAX        : saturation value of those counters
// ---------------------------------------------------------------------------
package b02_pkg;

    typedef enum logic [2:0] {
        A = 3'd0,
        B = 3'd1,
        C = 3'd2,
        D = 3'd3,
        E = 3'd4,
        F = 3'd5,
        G = 3'd6
    } b02_state_t;

    localparam b02_state_t B02_RESET_STATE = A;

    localparam int STAT_W = 8;

    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

endpackage : b02_pkg

// File: rtl/b02_step.sv
// ---------------------------------------------------------------------------
// b02_step
//   Pure combinational step of the b02 serial recognizer. Given the current
//   state and one serial bit it returns the next state and the match pulse.
//   The match pulse depends only on the current state (u=1 iff s==E).
//
// Ports:
//   s_i    in   3  current state code (raw bits so code 7 can be recovered)
//   bit_i  in   1  serial bit consumed by this step
//   s_o    out  3  next state
//   u_o    out  1  match pulse for this step
// ---------------------------------------------------------------------------
module b02_step
    import b02_pkg::*;
(
    input  logic [2:0] s_i,
    input  logic       bit_i,
    output b02_state_t s_o,
    output logic       u_o
);

    always_comb begin
        s_o = B;
        u_o = 1'b0;
        case (s_i)
            A: s_o = B;
            B: s_o = bit_i ? F : C;
            C: s_o = bit_i ? G : D;
            D: s_o = E;
            E: begin
                s_o = B;
                u_o = 1'b1;
            end
            F: s_o = G;
            G: s_o = bit_i ? A : E;
            // Code 7 never arises from legal operation; recover as if in A.
            default: begin
                s_o = B;
                u_o = 1'b0;
            end
        endcase
    end

endmodule : b02_step

// File: rtl/b02_line_scheduler.sv
// ---------------------------------------------------------------------------
// b02_line_scheduler
//   Time-shares one b02 serial recognizer among NUM_LINES serial lines.
//   Each line keeps its own saved recognizer context. Every cycle a
//   rotate-priority arbiter picks at most one requesting, non-flushed line;
//   that line's context advances by one bit through the shared b02_step.
//   Match pulses are reported with the index of the line that produced them.
//
// Handshake: req[i] is a level. On every edge where line i wins, linea[i]
//   is consumed; gnt[i] pulses in the following cycle. A requester keeps
//   req high and presents its next bit whenever gnt[i] is low or pulsing.
//
// Parameters:
//   NUM_LINES  number of serial lines (2..16)
//   IDW        line index width, derived from NUM_LINES
//
// Ports:
//   clock        in   1          rising-edge clock
//   reset        in   1          asynchronous active-high reset
//   req          in   NUM_LINES  per-line step request (level)
//   linea        in   NUM_LINES  per-line serial bit
//   flush        in   NUM_LINES  per-line synchronous context clear to A
//   gnt          out  NUM_LINES  registered one-hot grant of the last step
//   match_valid  out  1          registered match pulse of the last step
//   match_line   out  IDW        line index of the most recent match
//   stat_sel     in   IDW        match-counter read select
//   stat_cnt     out  8          match-counter read data
//
// Optional feature macro: B02_LINE_SCHEDULER_STATS_EN
//   Defined   : per-line saturating 8-bit match counters, readable via
//               stat_sel/stat_cnt, cleared by reset and by the line's flush.
//   Undefined : no counters; stat_cnt reads 0 and stat_sel is ignored.
// ---------------------------------------------------------------------------
module b02_line_scheduler
    import b02_pkg::*;
#(
    parameter  int NUM_LINES = 4,
    localparam int IDW       = $clog2(NUM_LINES)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_LINES-1:0] req,
    input  logic [NUM_LINES-1:0] linea,
    input  logic [NUM_LINES-1:0] flush,
    output logic [NUM_LINES-1:0] gnt,
    output logic                 match_valid,
    output logic [IDW-1:0]       match_line,
    input  logic [IDW-1:0]       stat_sel,
    output logic [STAT_W-1:0]    stat_cnt
);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    b02_state_t           ctx_q [NUM_LINES];
    b02_state_t           ctx_d [NUM_LINES];
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [NUM_LINES-1:0] gnt_q, gnt_d;
    logic                 match_valid_q, match_valid_d;
    logic [IDW-1:0]       match_line_q, match_line_d;

    // Arbitration results
    logic [NUM_LINES-1:0] elig;
    logic                 win_valid;
    logic [IDW-1:0]       win_idx;
    logic [IDW-1:0]       arb_cand;

    // Shared step datapath
    b02_state_t           step_s;
    logic                 step_u;
    logic                 step_match;

    // (base + off) mod NUM_LINES, with base < NUM_LINES and off < NUM_LINES.
    // One extra bit holds the sum so a single conditional subtract suffices,
    // which also covers non-power-of-two line counts.
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base,
                                                input int unsigned   off);
        logic [IDW:0] sum;
        sum = {1'b0, base} + (IDW+1)'(off);
        if (sum >= (IDW+1)'(NUM_LINES)) begin
            sum = sum - (IDW+1)'(NUM_LINES);
        end
        return sum[IDW-1:0];
    endfunction

    // -----------------------------------------------------------------------
    // Rotate-priority arbiter: first eligible line at ptr, ptr+1, ... (wrap).
    // A line being flushed this cycle is not eligible, so a flush always
    // takes precedence over a step on the same line.
    // -----------------------------------------------------------------------
    always_comb begin
        elig      = req & ~flush;
        win_valid = 1'b0;
        win_idx   = '0;
        arb_cand  = '0;
        for (int k = 0; k < NUM_LINES; k++) begin
            arb_cand = wrap_add(ptr_q, k);
            if (!win_valid && elig[arb_cand]) begin
                win_valid = 1'b1;
                win_idx   = arb_cand;
            end
        end
    end

    // Only the winning line's context and bit reach the shared recognizer.
    b02_step u_step (
        .s_i   (ctx_q[win_idx]),
        .bit_i (linea[win_idx]),
        .s_o   (step_s),
        .u_o   (step_u)
    );

    assign step_match = win_valid && step_u;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_LINES; i++) begin
            ctx_d[i] = ctx_q[i];
            if (flush[i]) begin
                ctx_d[i] = B02_RESET_STATE;
            end else if (win_valid && (win_idx == IDW'(i))) begin
                ctx_d[i] = step_s;
            end
        end

        gnt_d = '0;
        if (win_valid) begin
            gnt_d[win_idx] = 1'b1;
        end

        match_valid_d = step_match;
        // match_line keeps the last matching line between matches.
        match_line_d  = step_match ? win_idx : match_line_q;
        // The pointer moves past the winner only when a step happened.
        ptr_d         = win_valid ? wrap_add(win_idx, 1) : ptr_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                ctx_q[i] <= B02_RESET_STATE;
            end
            ptr_q         <= '0;
            gnt_q         <= '0;
            match_valid_q <= 1'b0;
            match_line_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_LINES; i++) begin
                ctx_q[i] <= ctx_d[i];
            end
            ptr_q         <= ptr_d;
            gnt_q         <= gnt_d;
            match_valid_q <= match_valid_d;
            match_line_q  <= match_line_d;
        end
    end

    assign gnt         = gnt_q;
    assign match_valid = match_valid_q;
    assign match_line  = match_line_q;

    // -----------------------------------------------------------------------
    // Optional per-line match statistics
    // -----------------------------------------------------------------------
`ifdef B02_LINE_SCHEDULER_STATS_EN
    logic [STAT_W-1:0] cnt_q [NUM_LINES];
    logic [STAT_W-1:0] cnt_d [NUM_LINES];

    always_comb begin
        for (int i = 0; i < NUM_LINES; i++) begin
            cnt_d[i] = cnt_q[i];
            // A flushed line is never the winner, so clearing here also
            // discards any match that might coincide with the flush.
            if (flush[i]) begin
                cnt_d[i] = '0;
            end else if (step_match && (win_idx == IDW'(i)) &&
                         (cnt_q[i] != STAT_MAX)) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LINES; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Combinational read; selects beyond the last line read as zero.
    always_comb begin
        stat_cnt = '0;
        if ({1'b0, stat_sel} < (IDW+1)'(NUM_LINES)) begin
            stat_cnt = cnt_q[stat_sel];
        end
    end
`else
    logic unused_stat_sel;

    assign unused_stat_sel = ^stat_sel;
    assign stat_cnt        = '0;
`endif

endmodule : b02_line_scheduler

// File: tb/tb_b02_line_scheduler.sv
// ---------------------------------------------------------------------------
// tb_b02_line_scheduler
//   Self-checking bench for b02_line_scheduler with NUM_LINES=4.
//   Table of hand-derived vectors, mid-run asynchronous reset sequence,
//   random traffic against a reference model, and match-counter checks
//   when B02_LINE_SCHEDULER_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_b02_line_scheduler;

    localparam int N = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] linea;
    logic [3:0] flush;
    logic [3:0] gnt;
    logic       match_valid;
    logic [1:0] match_line;
    logic [1:0] stat_sel;
    logic [7:0] stat_cnt;

    always #5 clock = ~clock;

    b02_line_scheduler #(.NUM_LINES(N)) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .linea       (linea),
        .flush       (flush),
        .gnt         (gnt),
        .match_valid (match_valid),
        .match_line  (match_line),
        .stat_sel    (stat_sel),
        .stat_cnt    (stat_cnt)
    );

    int checks = 0;
    int errors = 0;

    // {gnt[3:0], match_valid, match_line[1:0]}
    logic [6:0] exp_q[$];

    // Reference model state
    logic [2:0] m_ctx [N];
    logic [1:0] m_ptr;
    logic [1:0] m_ml;

    typedef struct {
        logic [3:0] req;
        logic [3:0] linea;
        logic [3:0] flush;
        logic [3:0] gnt;
        logic       mv;
        logic [1:0] ml;
    } vec_t;

    vec_t tab [30];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {u, next_state}.
    function automatic logic [3:0] ref_step(input logic [2:0] s, input logic b);
        case (s)
            3'd0: return {1'b0, 3'd1};
            3'd1: return {1'b0, b ? 3'd5 : 3'd2};
            3'd2: return {1'b0, b ? 3'd6 : 3'd3};
            3'd3: return {1'b0, 3'd4};
            3'd4: return {1'b1, 3'd1};
            3'd5: return {1'b0, 3'd6};
            3'd6: return {1'b0, b ? 3'd0 : 3'd4};
            default: return {1'b0, 3'd1};
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_ctx[i] = 3'd0;
        m_ptr = 2'd0;
        m_ml  = 2'd0;
        exp_q.delete();
    endtask

    task automatic model_edge(input logic [3:0] r, input logic [3:0] l, input logic [3:0] f,
                              output logic [3:0] g, output logic mv, output logic [1:0] ml);
        logic [3:0] el;
        logic       found;
        int         w;
        logic [3:0] res;
        el    = r & ~f;
        found = 1'b0;
        w     = 0;
        res   = 4'd0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (int'(m_ptr) + k) % N;
            if (!found && el[idx]) begin
                found = 1'b1;
                w     = idx;
            end
        end
        g  = 4'd0;
        mv = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (f[i]) m_ctx[i] = 3'd0;
        end
        if (found) begin
            res      = ref_step(m_ctx[w], l[w]);
            m_ctx[w] = res[2:0];
            g[w]     = 1'b1;
            mv       = res[3];
            if (res[3]) m_ml = 2'(w);
            m_ptr = 2'((w + 1) % N);
        end
        ml = m_ml;
    endtask

    // Drive one cycle; expectation comes from the table (use_tab) or model.
    task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic [3:0] f,
                         input bit use_tab, input logic [6:0] tab_exp);
        logic [3:0] mg;
        logic       mmv;
        logic [1:0] mml;
        logic [6:0] e;
        req   = r;
        linea = l;
        flush = f;
        model_edge(r, l, f, mg, mmv, mml);
        exp_q.push_back(use_tab ? tab_exp : {mg, mmv, mml});
        @(posedge clock);
        #1;
        if (exp_q.size() == 0) begin
            check("exp_queue_underflow", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("gnt", 32'(gnt), 32'(e[6:3]));
            check("match_valid", 32'(match_valid), 32'(e[2]));
            check("match_line", 32'(match_line), 32'(e[1:0]));
        end
    endtask

    task automatic pulse_reset();
        #3;
        reset = 1'b1;
        model_reset();
        @(posedge clock);
        #3;
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        req      = '0;
        linea    = '0;
        flush    = '0;
        stat_sel = '0;
        model_reset();

        // Rows 1-9: lone requester on line 0, bit 0 -> matches on grants 5 and 9
        for (int i = 0; i < 9; i++)
            tab[i] = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, (i == 4 || i == 8), 2'd0};
        // Rows 10-13: lines 0 and 2 alternate (ptr starts at 1)
        tab[9]  = '{4'b0101, 4'b0000, 4'b0000, 4'b0100, 1'b0, 2'd0};
        tab[10] = '{4'b0101, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0};
        tab[11] = '{4'b0101, 4'b0000, 4'b0000, 4'b0100, 1'b0, 2'd0};
        tab[12] = '{4'b0101, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0};
        // Rows 14-18: all request, rotation from line 1
        tab[13] = '{4'b1111, 4'b0000, 4'b0000, 4'b0010, 1'b0, 2'd0};
        tab[14] = '{4'b1111, 4'b0000, 4'b0000, 4'b0100, 1'b0, 2'd0};
        tab[15] = '{4'b1111, 4'b0000, 4'b0000, 4'b1000, 1'b0, 2'd0};
        tab[16] = '{4'b1111, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0};
        tab[17] = '{4'b1111, 4'b0000, 4'b0000, 4'b0010, 1'b0, 2'd0};
        // Row 19: line 0 sits in E, flushed while requesting -> no grant, no match
        tab[18] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b0, 2'd0};
        // Row 20: line 0 steps A->B, no match
        tab[19] = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0};
        // Row 21: flush line 1 with nobody requesting
        tab[20] = '{4'b0000, 4'b0000, 4'b0010, 4'b0000, 1'b0, 2'd0};
        // Rows 22-26: line 1 A->B, then bits 1,1,1 B->F->G->A, then A->B
        tab[21] = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 1'b0, 2'd0};
        for (int i = 22; i < 25; i++)
            tab[i] = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b0, 2'd0};
        tab[25] = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 1'b0, 2'd0};
        // Row 27: flushing line 0 leaves line 1 as winner
        tab[26] = '{4'b0011, 4'b0000, 4'b0001, 4'b0010, 1'b0, 2'd0};
        // Rows 28-30: line 2 D->E, E->B (match on line 2), then match_line holds
        tab[27] = '{4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b0, 2'd0};
        tab[28] = '{4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b1, 2'd2};
        tab[29] = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd2};

        // Reset state
        #12;
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_match_valid", 32'(match_valid), 32'd0);
        check("reset_match_line", 32'(match_line), 32'd0);
        check("reset_stat_cnt", 32'(stat_cnt), 32'd0);
        @(posedge clock);
        #3;
        reset = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 30; i++)
            drive(tab[i].req, tab[i].linea, tab[i].flush, 1'b1,
                  {tab[i].gnt, tab[i].mv, tab[i].ml});

        // Asynchronous reset between edges with two lines active
        for (int i = 0; i < 6; i++)
            drive(4'b0110, 4'($urandom_range(0, 15)), 4'b0000, 1'b0, 7'd0);
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_gnt", 32'(gnt), 32'd0);
        check("async_rst_match_valid", 32'(match_valid), 32'd0);
        check("async_rst_match_line", 32'(match_line), 32'd0);
        model_reset();
        @(posedge clock);
        #3;
        reset = 1'b0;
        drive(4'b1111, 4'b0000, 4'b0000, 1'b1, {4'b0001, 1'b0, 2'd0});
        drive(4'b1111, 4'b0000, 4'b0000, 1'b1, {4'b0010, 1'b0, 2'd0});
        drive(4'b1111, 4'b0000, 4'b0000, 1'b1, {4'b0100, 1'b0, 2'd0});
        drive(4'b1111, 4'b0000, 4'b0000, 1'b1, {4'b1000, 1'b0, 2'd0});
        drive(4'b1111, 4'b0000, 4'b0000, 1'b1, {4'b0001, 1'b0, 2'd0});

        // Random traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            logic [3:0] rf;
            rf = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), rf, 1'b0, 7'd0);
        end

        // Match statistics on line 2
        pulse_reset();
`ifdef B02_LINE_SCHEDULER_STATS_EN
        // First match on grant 5, then every 4th: 1041 grants give 260 matches.
        for (int i = 0; i < 1041; i++) begin
            drive(4'b0100, 4'b0000, 4'b0000, 1'b0, 7'd0);
            if (i == 12) begin
                stat_sel = 2'd2;
                #1;
                check("stat_cnt_after_3", 32'(stat_cnt), 32'd3);
            end
        end
        stat_sel = 2'd2;
        #1;
        check("stat_cnt_saturated", 32'(stat_cnt), 32'd255);
        stat_sel = 2'd3;
        #1;
        check("stat_cnt_other_line", 32'(stat_cnt), 32'd0);
        drive(4'b0000, 4'b0000, 4'b0100, 1'b0, 7'd0);
        stat_sel = 2'd2;
        #1;
        check("stat_cnt_after_flush", 32'(stat_cnt), 32'd0);
`else
        for (int i = 0; i < 13; i++)
            drive(4'b0100, 4'b0000, 4'b0000, 1'b0, 7'd0);
        stat_sel = 2'd2;
        #1;
        check("stat_cnt_disabled_sel2", 32'(stat_cnt), 32'd0);
        stat_sel = 2'd3;
        #1;
        check("stat_cnt_disabled_sel3", 32'(stat_cnt), 32'd0);
`endif

        check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_b02_line_scheduler
